braun_multiplier_pipe: RTL and testbench

- Parametrised, pipelined Braun array multiplier: unsigned N x N -> 2N product.
- Successor to the fixed 2-bit combinational Braun multiplier.
- Partial-product rows are split across STAGES register stages.
- Valid/ready handshake on both sides, with a tag carried alongside each operand pair.
- Sits between operand-issue logic and result consumers in the datapath; sustains one multiply per cycle when not back-pressured.

---
 rtl/braun_multiplier_pipe.sv | 161 ++++++++++++++++
 tb/tb_braun_multiplier_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/braun_multiplier_pipe.sv
// Pipelined Braun array multiplier: N x N -> 2N product, valid/ready with a tag per operation.
// Define BRAUN_SIGNED_EN for two's complement operands (Baugh-Wooley array).
module braun_multiplier_pipe #(
    parameter int N      = 8,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       a,
    input  logic [N-1:0]       b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int W = 2 * N;

`ifdef BRAUN_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    // Baugh-Wooley correction constants enter the array as the initial carry vector.
    localparam logic [W-1:0] INIT_C = SIGNED_MODE ? ((W'(1) << N) | (W'(1) << (W - 1))) : '0;

    function automatic logic pp_bit(input logic [N-1:0] x, input logic [N-1:0] y,
                                    input int i, input int j);
        logic bit_v;
        bit_v = x[j] & y[i];
        if (SIGNED_MODE && ((i == N - 1) != (j == N - 1)))
            bit_v = ~bit_v;
        return bit_v;
    endfunction

    function automatic logic [W-1:0] pp_row(input logic [N-1:0] x, input logic [N-1:0] y,
                                            input int i);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++)
            r[i+j] = pp_bit(x, y, i, j);
        return r;
    endfunction

    // Adds partial-product rows lo..hi-1 into the sum/carry pair, one full-adder row each.
    function automatic logic [2*W-1:0] csa_rows(input logic [W-1:0] s_in, input logic [W-1:0] c_in,
                                                input logic [N-1:0] x, input logic [N-1:0] y,
                                                input int lo, input int hi);
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W-1:0] r;
        logic [W-1:0] ns;
        s = s_in;
        c = c_in;
        for (int i = 1; i < N; i++) begin
            if (i >= lo && i < hi) begin
                r  = pp_row(x, y, i);
                ns = s ^ c ^ r;
                c  = ((s & c) | (s & r) | (c & r)) << 1;
                s  = ns;
            end
        end
        return {s, c};
    endfunction

    logic               adv;
    logic               out_v_q;
    logic [W-1:0]       p_q;
    logic [TAG_W-1:0]   tag_q;

    assign adv       = !out_v_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_v_q;
    assign p         = p_q;
    assign out_tag   = tag_q;

    generate
        if (STAGES == 1) begin : g_single
            logic [2*W-1:0] cs;

            assign cs   = csa_rows(pp_row(a, b, 0), INIT_C, a, b, 1, N);
            assign busy = out_v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_v_q <= 1'b0;
                    p_q     <= '0;
                    tag_q   <= '0;
                end else if (adv) begin
                    out_v_q <= in_valid;
                    p_q     <= cs[2*W-1:W] + cs[W-1:0];
                    tag_q   <= in_tag;
                end
            end
        end else begin : g_pipe
            localparam int P = STAGES - 1;

            logic [W-1:0]     st_s   [P];
            logic [W-1:0]     st_c   [P];
            logic [N-1:0]     st_a   [P];
            logic [N-1:0]     st_b   [P];
            logic [TAG_W-1:0] st_tag [P];
            logic [P-1:0]     st_v;
            logic [2*W-1:0]   cs     [P];

            // Rows 1..N-1 spread evenly over the P array stages; the merge adder feeds the output register.
            for (genvar k = 0; k < P; k++) begin : g_row
                localparam int LO = 1 + (k * (N - 1)) / P;
                localparam int HI = 1 + ((k + 1) * (N - 1)) / P;
                if (k == 0) begin : g_first
                    assign cs[k] = csa_rows(pp_row(a, b, 0), INIT_C, a, b, LO, HI);
                end else begin : g_next
                    assign cs[k] = csa_rows(st_s[k-1], st_c[k-1], st_a[k-1], st_b[k-1], LO, HI);
                end
            end

            assign busy = out_v_q | (|st_v);

            always_ff @(posedge clk) begin
                if (rst) begin
                    st_v    <= '0;
                    out_v_q <= 1'b0;
                    p_q     <= '0;
                    tag_q   <= '0;
                    for (int k = 0; k < P; k++) begin
                        st_s[k]   <= '0;
                        st_c[k]   <= '0;
                        st_a[k]   <= '0;
                        st_b[k]   <= '0;
                        st_tag[k] <= '0;
                    end
                end else if (adv) begin
                    st_v[0]   <= in_valid;
                    st_a[0]   <= a;
                    st_b[0]   <= b;
                    st_tag[0] <= in_tag;
                    for (int k = 1; k < P; k++) begin
                        st_v[k]   <= st_v[k-1];
                        st_a[k]   <= st_a[k-1];
                        st_b[k]   <= st_b[k-1];
                        st_tag[k] <= st_tag[k-1];
                    end
                    for (int k = 0; k < P; k++) begin
                        st_s[k] <= cs[k][2*W-1:W];
                        st_c[k] <= cs[k][W-1:0];
                    end
                    out_v_q <= st_v[P-1];
                    p_q     <= st_s[P-1] + st_c[P-1];
                    tag_q   <= st_tag[P-1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_braun_multiplier_pipe.sv
// Scoreboard bench for braun_multiplier_pipe (N=8/STAGES=3 main instance, N=2/STAGES=1 corner instance).
module tb_braun_multiplier_pipe;

    localparam int N  = 8;
    localparam int ST = 3;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready, busy;
    logic [N-1:0]     a, b;
    logic [TW-1:0]    in_tag, out_tag;
    logic [2*N-1:0]   p;

    logic             iv2, ir2, ov2, busy2;
    logic [1:0]       a2, b2;
    logic [0:0]       tag2_in, tag2_out;
    logic [3:0]       p2;

    braun_multiplier_pipe #(.N(N), .STAGES(ST), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .p(p),
        .out_tag(out_tag), .busy(busy)
    );

    braun_multiplier_pipe #(.N(2), .STAGES(1), .TAG_W(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .in_tag(tag2_in), .out_valid(ov2), .out_ready(1'b1), .p(p2),
        .out_tag(tag2_out), .busy(busy2)
    );

    typedef struct packed {
        logic [TW-1:0]  tag;
        logic [2*N-1:0] prod;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   run_len = 0;
    int   max_run = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] model_mul(input logic [N-1:0] x, input logic [N-1:0] y);
`ifdef BRAUN_SIGNED_EN
        logic signed [2*N-1:0] xs, ys;
        xs = $signed(x);
        ys = $signed(y);
        return xs * ys;
`else
        logic [2*N-1:0] xe, ye;
        xe = x;
        ye = y;
        return xe * ye;
`endif
    endfunction

    function automatic logic [3:0] model_mul2(input logic [1:0] x, input logic [1:0] y);
`ifdef BRAUN_SIGNED_EN
        logic signed [3:0] xs, ys;
        xs = $signed(x);
        ys = $signed(y);
        return xs * ys;
`else
        logic [3:0] xe, ye;
        xe = x;
        ye = y;
        return xe * ye;
`endif
    endfunction

    // Output side popped before input side: nothing accepted at an edge can leave at that edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            run_len = 0;
        end else begin
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("stale_out", out_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("p", p, e.prod);
                    check("out_tag", out_tag, e.tag);
                    n_out++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back({in_tag, model_mul(a, b)});
        end
    end

    task automatic drive(input logic v, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [TW-1:0] t);
        int   guard;
        logic rdy;
        guard    = 0;
        in_valid = v;
        a        = x;
        b        = y;
        in_tag   = t;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (v && !rdy && guard < 100);
        if (guard >= 100) check("drive_timeout", rdy, 1'b1);
    endtask

    task automatic wait_out();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!out_valid && g < 30);
        check("wait_out", out_valid, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ov_seq [8];
        int   base;
        int   first;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; in_tag = '0;
        iv2 = 1'b0; a2 = '0; b2 = '0; tag2_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_p", p, 16'h0000);
        check("rst_out_tag", out_tag, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Latency: valid after the 3rd edge counting the capture edge, for one cycle only.
        drive(1'b1, 8'hFF, 8'hFF, 4'h5);
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                check("lat_valid", out_valid, 1'b1);
                check("lat_p", p, model_mul(8'hFF, 8'hFF));
                check("lat_tag", out_tag, 4'h5);
            end else begin
                check("lat_idle", out_valid, 1'b0);
            end
        end
        @(posedge clk); #1;

        // Arithmetic corners with spec-given constants.
        drive(1'b1, 8'hFF, 8'h02, 4'h1);
        in_valid = 1'b0;
        wait_out();
`ifdef BRAUN_SIGNED_EN
        check("ff_x_02", p, 16'hFFFE);
`else
        check("ff_x_02", p, 16'h01FE);
`endif
        @(posedge clk); #1;
        drive(1'b1, 8'h80, 8'h80, 4'h2);
        in_valid = 1'b0;
        wait_out();
        check("80_x_80", p, 16'h4000);
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;

        // Full-rate streaming.
        base = n_out; max_run = 0; run_len = 0;
        for (int i = 0; i < 64; i++)
            drive(1'b1, N'($urandom), N'($urandom), TW'(i));
        in_valid = 1'b0;
        repeat (ST + 3) @(negedge clk);
        check("stream_count", n_out - base, 64);
        check("stream_run", max_run, 64);
        @(posedge clk); #1;

        // Backpressure: stall a pending result for 5 cycles, then drain.
        base = n_out;
        out_ready = 1'b0;
        drive(1'b1, 8'd7, 8'd9, 4'h3);
        drive(1'b1, 8'd11, 8'd13, 4'h4);
        in_valid = 1'b0;
        wait_out();
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_p_stable", p, model_mul(8'd7, 8'd9));
            check("bp_tag_stable", out_tag, 4'h3);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (ST + 3) @(negedge clk);
        check("bp_drain", n_out - base, 2);
        check("bp_empty", sb.size(), 0);
        @(posedge clk); #1;

        // Bubble between two valid pairs.
        drive(1'b1, 8'd3, 8'd5, 4'h6);
        drive(1'b0, 8'd0, 8'd200, 4'h7);
        drive(1'b1, 8'd0, 8'd200, 4'h8);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ov_seq[i] = out_valid;
        end
        first = -1;
        for (int i = 0; i < 8; i++)
            if (first < 0 && ov_seq[i]) first = i;
        check("bub_found", first >= 0 && first < 5, 1'b1);
        if (first >= 0 && first < 5) begin
            check("bub_gap", ov_seq[first+1], 1'b0);
            check("bub_second", ov_seq[first+2], 1'b1);
            check("bub_after", ov_seq[first+3], 1'b0);
        end
        @(posedge clk); #1;

        // Reset mid-operation: nothing issued before the reset may emerge.
        base = n_out;
        drive(1'b1, 8'd21, 8'd3, 4'h9);
        drive(1'b1, 8'd22, 8'd4, 4'hA);
        drive(1'b1, 8'd23, 8'd5, 4'hB);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_p", p, 16'h0000);
        check("mid_rst_tag", out_tag, 4'h0);
        repeat (8) @(negedge clk);
        check("mid_rst_no_stale", n_out - base, 0);
        @(posedge clk); #1;

        // N=2, STAGES=1: exhaustive, one-edge latency.
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                a2 = 2'(x); b2 = 2'(y); iv2 = 1'b1;
                @(posedge clk); #1 iv2 = 1'b0;
                @(negedge clk);
                check("n2_valid", ov2, 1'b1);
                check("n2_p", p2, model_mul2(2'(x), 2'(y)));
                check("n2_tag", tag2_out, 1'b1);
                @(posedge clk); #1;
            end
        end
`ifndef BRAUN_SIGNED_EN
        check("n2_3x3", model_mul2(2'd3, 2'd3), 4'h9);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
